alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Registered, parametrised successor of the combinational datapath ALU, with a valid/ready handshake on input and output. It adds an iterative shift-add multiply and an internal NZCV flag register. That register is written only when the S bit is set and supplies the carry-in for ADC/SBC. It sits between the execute-stage operand latch and the writeback/status path of the pipelined core.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 4)
CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; do not override)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation (high only in IDLE)
alu_command  input  4  opcode, sampled on acceptance
s_in  input  1  update flags on completion when 1
alu_in1  input  WIDTH  operand A
alu_in2  input  WIDTH  operand B
out_valid  output  1  alu_out valid, held until consumed
out_ready  input  1  consumer accepts result
alu_out  output  WIDTH  registered result
status_register  output  4  flag register: [3]=Z, [2]=C, [1]=N, [0]=V

Behaviour:
- Reset (async, rst=1): state=IDLE, alu_out=0, status_register=0, out_valid=0, in_ready=1, counter=0, operand regs=0.
- Accept = in_valid & in_ready. On accept, latch opcode, s_in, operands and the current C flag (cin).
- States:
  - IDLE: on accept, a non-MUL op goes to DONE; MUL (4'b1010) goes to MUL.
  - MUL: 1 iteration/cycle for WIDTH cycles, then DONE.
  - DONE: out_valid=1; on out_ready go to IDLE.
- Latency:
  - Non-MUL: result and flags registered on the accept edge; out_valid high the next cycle.
  - MUL: out_valid high WIDTH+1 cycles after accept.
- Throughput: no new op is accepted in MUL or DONE. A new op may be accepted in the cycle after the DONE->IDLE handshake.
- Opcodes; arithmetic uses (WIDTH+1)-bit zero-extended operands, C = bit WIDTH of that result:
  - 0001 MOV: B
  - 1001 MVN: ~B
  - 0010 ADD: A+B
  - 0011 ADC: A+B+cin
  - 0100 SUB: A-B
  - 0101 SBC: A-B-(~cin)
  - 0110 AND: A&B
  - 0111 ORR: A|B
  - 1000 EOR: A^B
  - 1010 MUL: low WIDTH bits of A*B, unsigned shift-add (add B<<i when A[i]=1, i = 0..WIDTH-1)
  - any other opcode: result 0
- Overflow V:
  - ADD/ADC: A[msb]==B[msb] and R[msb]!=A[msb].
  - SUB/SBC: A[msb]!=B[msb] and R[msb]!=A[msb].
  - All other ops: C=0 and V=0.
- Flags: on the edge the result is registered, if latched s=1, write status_register = {Z=(R==0), C, N=R[msb], V}. If s=0, status_register is unchanged.
- cin is the flag value at acceptance, never a mid-operation value.
- alu_out holds its value outside DONE; it is updated only on the edge entering DONE.
- Boundaries:
  - out_ready low in DONE: result and out_valid held indefinitely.
  - in_valid during MUL/DONE: ignored; in_ready=0; no operand change.
  - rst mid-MUL or in DONE: immediate return to reset values; partial product discarded.
  - Counter terminates at WIDTH-1; the accumulator wraps modulo 2^WIDTH.
  - Undefined opcode with s=1: flags become Z=1, N=0, C=0, V=0.

Test Plan:
- WIDTH=32, ADD s=1: A=FFFFFFFF, B=00000001 -> cycle+1 alu_out=0, status_register=4'b1100 (Z,C).
- ADD s=1: A=7FFFFFFF, B=1 -> alu_out=80000000, status=4'b0011 (N,V). Then ADC s=0 A=1 B=1 with C=0 -> alu_out=2, status unchanged 0011.
- SUB s=1: A=5, B=5 -> 0, Z=1. SBC A=5 B=3 with cin=0 -> 1. SBC with cin=1 -> 2.
- MUL: A=0000FFFF, B=00010001 -> out_valid exactly 33 cycles after accept, alu_out=FFFFFFFF. In_valid pulses during MUL are ignored, with in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and alu_out stable. Once out_ready=1, in_ready rises the next cycle.
- Reset mid-MUL, at iteration 10 -> all outputs 0 and in_ready=1 immediately. A subsequent MOV B=ABCD1234 returns ABCD1234 with no residue.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, iterative shift-add
// multiply and an NZCV-style flag register.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operation request handshake (in_ready high only in IDLE)
//   alu_command       4-bit opcode, sampled on acceptance
//   s_in              update status_register on completion when 1
//   alu_in1/alu_in2   operands A and B
//   out_valid/out_ready result handshake, result held until consumed
//   alu_out           registered result
//   status_register   flags: [3]=Z, [2]=C, [1]=N, [0]=V
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_command,
  input  logic             s_in,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       status_register
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned EXT_W = WIDTH + 1;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Single-cycle ops: returns {C, V, result}.
  function automatic logic [WIDTH+1:0] alu_eval(
    input logic [3:0]       cmd,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0]   ea;
    logic [WIDTH:0]   eb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             ncin;
    ea   = {1'b0, a};
    eb   = {1'b0, b};
    sum  = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    ncin = ~cin;
    case (cmd)
      OP_MOV: r = b;
      OP_MVN: r = ~b;
      OP_ADD, OP_ADC: begin
        sum = ea + eb + ((cmd == OP_ADC) ? EXT_W'(cin) : '0);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        sum = ea - eb - ((cmd == OP_SBC) ? EXT_W'(ncin) : '0);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_EOR: r = a ^ b;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  function automatic logic [3:0] pack_flags(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v
  );
    return {(r == '0), c, r[WIDTH-1], v};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               s_q, s_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_out_d;
  logic [3:0]         status_d;
  logic               out_valid_d;
  logic               in_ready_d;
  logic [WIDTH+1:0]   eval;
  logic [WIDTH-1:0]   mul_step;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      op_a_q          <= '0;
      op_b_q          <= '0;
      s_q             <= 1'b0;
      acc_q           <= '0;
      cnt_q           <= '0;
      alu_out         <= '0;
      status_register <= '0;
      out_valid       <= 1'b0;
      in_ready        <= 1'b1;
    end else begin
      state_q         <= state_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      s_q             <= s_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      alu_out         <= alu_out_d;
      status_register <= status_d;
      out_valid       <= out_valid_d;
      in_ready        <= in_ready_d;
    end
  end

  // Next-state and datapath. Non-MUL ops resolve on the accept edge using the
  // C flag as it stands at acceptance, so only MUL carries latched operands.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    s_d         = s_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    alu_out_d   = alu_out;
    status_d    = status_register;
    out_valid_d = out_valid;
    in_ready_d  = in_ready;
    eval        = alu_eval(alu_command, alu_in1, alu_in2, status_register[2]);
    // One shift-add iteration: add B<<i when A[i] is set, wrapping mod 2^WIDTH.
    mul_step    = acc_q + (op_a_q[cnt_q[IDX_W-1:0]] ? (op_b_q << cnt_q) : '0);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_a_d     = alu_in1;
          op_b_d     = alu_in2;
          s_d        = s_in;
          in_ready_d = 1'b0;
          if (alu_command == OP_MUL) begin
            state_d = S_MUL;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d     = S_DONE;
            alu_out_d   = eval[WIDTH-1:0];
            out_valid_d = 1'b1;
            if (s_in) begin
              status_d = pack_flags(eval[WIDTH-1:0], eval[WIDTH+1], eval[WIDTH]);
            end
          end
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          alu_out_d   = mul_step;
          out_valid_d = 1'b1;
          if (s_q) begin
            status_d = pack_flags(mul_step, 1'b0, 1'b0);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): stimulus pushes expected results,
// a negedge monitor pops and compares on each consumed result.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_command;
  logic        s_in;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic [3:0]  status_register;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic [3:0]  st;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_command     (alu_command),
    .s_in            (s_in),
    .alu_in1         (alu_in1),
    .alu_in2         (alu_in2),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .alu_out         (alu_out),
    .status_register (status_register)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", alu_out, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_out"}, alu_out, e.out);
        chk({e.name, "_flags"}, {28'd0, status_register}, {28'd0, e.st});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic op(input string name, input logic [3:0] cmd, input logic s,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eo, input logic [3:0] es);
    int n = 0;
    wait_ready(name);
    alu_command = cmd;
    s_in        = s;
    alu_in1     = a;
    alu_in2     = b;
    in_valid    = 1'b1;
    sb.push_back('{name, eo, es});
    tick();
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic rdy_bad;

    rst = 1'b1; in_valid = 1'b0; alu_command = 4'd0; s_in = 1'b0;
    alu_in1 = '0; alu_in2 = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", alu_out, 32'd0);
    chk("rst_flags", {28'd0, status_register}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    op("add_carry", 4'b0010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100);
    op("add_ovf",   4'b0010, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011);
    op("adc_nos",   4'b0011, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0011);
    op("sub_zero",  4'b0100, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000);
    op("sbc_c0",    4'b0101, 1'b0, 32'h00000005, 32'h00000003, 32'h00000001, 4'b1000);
    op("add_setc",  4'b0010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100);
    op("sbc_c1",    4'b0101, 1'b1, 32'h00000005, 32'h00000003, 32'h00000002, 4'b0000);
    op("mov",       4'b0001, 1'b1, 32'h12345678, 32'h80000000, 32'h80000000, 4'b0010);
    op("mvn",       4'b1001, 1'b1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 4'b0010);
    op("and",       4'b0110, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010);
    op("orr",       4'b0111, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b0010);
    op("eor",       4'b1000, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000);
    op("undef",     4'b1111, 1'b1, 32'h00000001, 32'h00000002, 32'h00000000, 4'b1000);
    op("sub_borrow",4'b0100, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110);
    op("adc_c1",    4'b0011, 1'b1, 32'h00000001, 32'h00000001, 32'h00000003, 4'b0000);
    op("sub_ovf",   4'b0100, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001);

    // MUL with ignored in_valid traffic, latency and backpressure.
    out_ready = 1'b0;
    wait_ready("mul");
    alu_command = 4'b1010; s_in = 1'b1;
    alu_in1 = 32'h0000FFFF; alu_in2 = 32'h00010001; in_valid = 1'b1;
    sb.push_back('{"mul", 32'hFFFFFFFF, 4'b0010});
    tick();
    alu_command = 4'b0001; alu_in2 = 32'hDEADBEEF;
    lat = 0; rdy_bad = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_bad = 1'b1;
      if (lat == 20) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("mul_latency", 32'(lat), 32'd33);
    chk("mul_in_ready_low", {31'd0, rdy_bad}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out", alu_out, 32'hFFFFFFFF);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    chk("consume_in_ready", {31'd0, in_ready}, 32'd1);
    chk("consume_valid", {31'd0, out_valid}, 32'd0);
    chk("mul_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // Reset in the middle of a multiply.
    wait_ready("mul_rst");
    alu_command = 4'b1010; s_in = 1'b1;
    alu_in1 = 32'h00000003; alu_in2 = 32'h00000005; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midmul_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out", alu_out, 32'd0);
    chk("midrst_flags", {28'd0, status_register}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    op("mov_after_rst", 4'b0001, 1'b0, 32'h00000000, 32'hABCD1234, 32'hABCD1234, 4'b0000);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
